// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes
// and a width helper for the bit-timing counters.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Bits needed to hold 0..value-1; never less than one so counters stay legal.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter; depth is 2**AW and a
// simultaneous write and pop is accepted even when the FIFO is full.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic             rd,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             push;

   assign full  = (level == DEPTH);
   assign empty = (level == '0);
   assign push  = wr && (!full || rd);
   assign dout  = mem[rptr];

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (rd)   rptr <= rptr + AW'(1);
         case ({push, rd})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered, parametrised UART transmitter. Define UART_TX_PARITY_EN to build
// the parity bit stage; without it parity_mode is ignored.
module uart_tx_cfg #(
   parameter int DBIT    = 8,
   parameter int OVS     = 16,
   parameter int SB_TICK = 16,
   parameter int FIFO_AW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_tick,
   input  logic              wr_en,
   input  logic [DBIT-1:0]   din,
   input  logic [1:0]        parity_mode,
   output logic              full,
   output logic [FIFO_AW:0]  fifo_level,
   output logic              ovf_tick,
   output logic              busy,
   output logic              tx_done_tick,
   output logic              tx
);

   import uart_pkg::*;

   localparam int SW = clog2((OVS > SB_TICK) ? OVS : SB_TICK);
   localparam int NW = clog2(DBIT);
   localparam logic [SW-1:0] OVS_LAST  = SW'(OVS - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   tx_state_t       state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] shift_reg, shift_next;
   logic            tx_reg, tx_next;
   logic            ovf_reg, ovf_next;
   logic            pop;
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_dout;

`ifdef UART_TX_PARITY_EN
   logic            par_reg, par_next;
   logic [1:0]      mode_reg, mode_next;
   logic            par_active;

   assign par_active = (mode_reg == PAR_EVEN) || (mode_reg == PAR_ODD);
`else
   logic            unused_mode;

   assign unused_mode = ^parity_mode;
`endif

   uart_tx_fifo #(
      .WIDTH (DBIT),
      .AW    (FIFO_AW)
   ) fifo_i (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en),
      .rd    (pop),
      .din   (din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
         ovf_reg   <= ovf_next;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_reg  <= 1'b0;
         mode_reg <= PAR_NONE;
      end else begin
         par_reg  <= par_next;
         mode_reg <= mode_next;
      end
   end
`endif

   // Frame sequencing: every state advances on its last s_tick, counted by s.
   always_comb begin
      state_next   = state_reg;
      s_next       = s_reg;
      n_next       = n_reg;
      shift_next   = shift_reg;
      pop          = 1'b0;
      tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_next     = par_reg;
      mode_next    = mode_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
               s_next     = '0;
               n_next     = '0;
               state_next = START;
`ifdef UART_TX_PARITY_EN
               mode_next  = parity_mode;
               par_next   = 1'b0;
`endif
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == OVS_LAST) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == OVS_LAST) begin
                  s_next     = '0;
                  shift_next = shift_reg >> 1;
`ifdef UART_TX_PARITY_EN
                  par_next   = par_reg ^ shift_reg[0];
`endif
                  if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_next = par_active ? PARITY : STOP;
`else
                     state_next = STOP;
`endif
                  end else begin
                     n_next = n_reg + NW'(1);
                  end
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_reg == OVS_LAST) begin
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s_reg == STOP_LAST) begin
                  s_next       = '0;
                  state_next   = IDLE;
                  tx_done_tick = 1'b1;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Line level follows the current state and is registered, so tx lags by one cycle.
   always_comb begin
      tx_next = 1'b1;
      case (state_reg)
         START:  tx_next = 1'b0;
         DATA:   tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx_next = (mode_reg == PAR_ODD) ? ~par_reg : par_reg;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   always_comb begin
      ovf_next = wr_en && full && !pop;
   end

   // Queued words keep busy high through the single IDLE cycle between frames.
   assign busy     = (state_reg != IDLE) || !fifo_empty;
   assign ovf_tick = ovf_reg;
   assign tx       = tx_reg;

endmodule
